// File: rtl/sp_table_loader.sv
// Streams a spline basis table image into basis ROM bank A (full range) and bank B (upper part).
// Optional load checksum on o_cksum is built only when SP_LOAD_CKSUM_EN is defined.
module sp_table_loader #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 10,
  parameter int B_BASE = 512
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_we_a,
  output logic              o_we_b,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [15:0]       o_cksum
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'((1 << ADDR_W) - 1);
  localparam logic [CNT_W-1:0] CNT_B_FIRST = CNT_W'(B_BASE);

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_p0, busy_p0, done_p0;
  logic              beat_p0, start_p0, err_set_p0;
  logic              we_a_p1, we_b_p1;
  logic [ADDR_W-1:0] waddr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ready_p0   = 1'b0;
    busy_p0    = 1'b0;
    done_p0    = 1'b0;
    beat_p0    = 1'b0;
    start_p0   = 1'b0;
    err_set_p0 = 1'b0;
    case (state_q)
      IDLE: begin
        start_p0 = i_start;
        if (i_start) state_d = LOAD_A;
      end
      LOAD_A: begin
        ready_p0   = 1'b1;
        busy_p0    = 1'b1;
        beat_p0    = i_valid;
        err_set_p0 = i_start;
        if (i_valid && cnt_q == CNT_LAST) state_d = LOAD_B;
      end
      LOAD_B: begin
        ready_p0   = 1'b1;
        busy_p0    = 1'b1;
        beat_p0    = i_valid;
        err_set_p0 = i_start;
        if (i_valid && cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        done_p0    = 1'b1;
        err_set_p0 = i_start;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0 -> p1: accepted beat becomes a registered bank write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      err_q    <= 1'b0;
      we_a_p1  <= 1'b0;
      we_b_p1  <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      we_a_p1 <= beat_p0 && (state_q == LOAD_A);
      we_b_p1 <= beat_p0 && (state_q == LOAD_B);
      if (start_p0) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        if (err_set_p0) err_q <= 1'b1;
        if (beat_p0) begin
          // The A->B hand-off jumps straight to the bank B base so no bubble is needed
          if (state_q == LOAD_A && cnt_q == CNT_LAST) cnt_q <= CNT_B_FIRST;
          else                                        cnt_q <= cnt_q + 1'b1;
        end
      end
      if (beat_p0) begin
        waddr_p1 <= cnt_q[ADDR_W-1:0];
        wdata_p1 <= i_data;
      end
    end
  end

`ifdef SP_LOAD_CKSUM_EN
  function automatic logic [15:0] cksum_add(input logic [15:0] acc, input logic [DATA_W-1:0] d);
    return acc + 16'(d);
  endfunction

  logic [15:0] cksum_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     cksum_q <= '0;
    else if (start_p0) cksum_q <= '0;
    else if (beat_p0)  cksum_q <= cksum_add(cksum_q, i_data);
  end

  assign o_cksum = cksum_q;
`else
  assign o_cksum = '0;
`endif

  assign o_ready = ready_p0;
  assign o_busy  = busy_p0;
  assign o_done  = done_p0;
  assign o_err   = err_q;
  assign o_we_a  = we_a_p1;
  assign o_we_b  = we_b_p1;
  assign o_waddr = waddr_p1;
  assign o_wdata = wdata_p1;

endmodule
